// File: rtl/vga_timing_gen_if.sv
// Bundle of the VGA timing generator's per-pixel signals.
//   master : the generator (receives ce/pix_in, drives timing outputs)
//   slave  : the consumer/driver side (drives ce/pix_in, observes outputs)
// Signals:
//   ce          pixel clock-enable
//   pix_in      external pixel value
//   test_mode   checkerboard select (only with VGA_TEST_PATTERN_EN defined)
//   x, y        current horizontal / vertical counts
//   de          stage-0 active region
//   line_start  high while x==0
//   frame_start high while x==0 && y==0
//   frame_cnt   completed-frame counter (8 bit, wraps)
//   hsync/vsync delayed syncs at configured polarity
//   video       delayed, blanked pixel output
// Handshake: there is no valid/ready pair here; ce is a qualifier, and every
// output is meaningful on every clk, changing only after an edge with ce=1.
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          ce;
  logic          pix_in;
`ifdef VGA_TEST_PATTERN_EN
  logic          test_mode;
`endif
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          de;
  logic          line_start;
  logic          frame_start;
  logic [7:0]    frame_cnt;
  logic          hsync;
  logic          vsync;
  logic          video;

`ifdef VGA_TEST_PATTERN_EN
  modport master (
    input  ce, pix_in, test_mode,
    output x, y, de, line_start, frame_start, frame_cnt, hsync, vsync, video
  );
  modport slave (
    output ce, pix_in, test_mode,
    input  x, y, de, line_start, frame_start, frame_cnt, hsync, vsync, video
  );
`else
  modport master (
    input  ce, pix_in,
    output x, y, de, line_start, frame_start, frame_cnt, hsync, vsync, video
  );
  modport slave (
    output ce, pix_in,
    input  x, y, de, line_start, frame_start, frame_cnt, hsync, vsync, video
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator.
// Counts pixels/lines on clk edges qualified by bus.ce, decodes stage-0
// timing (de, line/frame strobes, raw syncs) and delays the syncs and the
// blanked pixel by PIPE_DLY ce-cycles to match a downstream pixel pipeline.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    vga_timing_gen_if.master (ce, pix_in[, test_mode] in; timing out)
// Optional feature macro: VGA_TEST_PATTERN_EN -- adds bus.test_mode, which
// swaps pix_in for an internal x[3]^y[3] checkerboard.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 2,
  parameter int CW       = 10
) (
  input  logic        clk,
  input  logic        reset,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Delay-line word: {hs, vs, de} plus the checkerboard bit when enabled.
`ifdef VGA_TEST_PATTERN_EN
  localparam int LW = 4;
`else
  localparam int LW = 3;
`endif

`ifndef SYNTHESIS
  if (H_SYNC < 1 || V_SYNC < 1 || PIPE_DLY < 1 || PIPE_DLY > 8 ||
      H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_param_check
    $error("vga_timing_gen: illegal parameter set");
  end
`endif

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [7:0]    frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (bus.ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Stage-0 decode. Syncs are carried internally as active-high and only
  // converted to the configured polarity at the output.
  logic hs0, vs0, de0;
  logic [LW-1:0] vec0;

  assign hs0 = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs0 = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign de0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);

`ifdef VGA_TEST_PATTERN_EN
  assign vec0 = {hs0, vs0, de0, h_cnt[3] ^ v_cnt[3]};
`else
  assign vec0 = {hs0, vs0, de0};
`endif

  // The last of the PIPE_DLY stages is the output register (hs, vs, video);
  // the preceding PIPE_DLY-1 stages carry the raw word. tail_in is what
  // feeds the output register.
  logic [LW-1:0] tail_in;

  if (PIPE_DLY == 1) begin : g_dly1
    assign tail_in = vec0;
  end else begin : g_dlyn
    logic [LW-1:0] mid [PIPE_DLY-1];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < PIPE_DLY - 1; k++) mid[k] <= '0;
      end else if (bus.ce) begin
        mid[0] <= vec0;
        for (int k = 1; k < PIPE_DLY - 1; k++) mid[k] <= mid[k-1];
      end
    end
    assign tail_in = mid[PIPE_DLY-2];
  end

  logic pix_src;
`ifdef VGA_TEST_PATTERN_EN
  assign pix_src = bus.test_mode ? tail_in[0] : bus.pix_in;
`else
  assign pix_src = bus.pix_in;
`endif

  logic hs_q, vs_q, video_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      video_q <= 1'b0;
    end else if (bus.ce) begin
      hs_q    <= tail_in[LW-1];
      vs_q    <= tail_in[LW-2];
      video_q <= pix_src & tail_in[LW-3];
    end
  end

  assign bus.x           = h_cnt;
  assign bus.y           = v_cnt;
  assign bus.de          = de0;
  assign bus.line_start  = (h_cnt == '0);
  assign bus.frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign bus.frame_cnt   = frame_cnt;
  assign bus.hsync       = hs_q ^ ~HS_POL;
  assign bus.vsync       = vs_q ^ ~VS_POL;
  assign bus.video       = video_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance (a) and a
// small-timing instance (b, HS_POL=1). Expected values come from a simple
// coordinate model computed here from the number of ce edges since reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a;
  logic reset_b;

  vga_timing_gen_if #(.CW(10)) ifa ();
  vga_timing_gen_if #(.CW(10)) ifb ();

  vga_timing_gen dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (ifa.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DLY(2), .CW(10)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (ifb.master)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int hd, vd, e, ls_prev, rise0, rise1, lowcnt, first_low;
    bit found;

    reset_a = 1'b1;
    reset_b = 1'b1;
    ifa.ce = 1'b1; ifa.pix_in = 1'b1;
    ifb.ce = 1'b1; ifb.pix_in = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    ifa.test_mode = 1'b0;
    ifb.test_mode = 1'b0;
`endif
    tick(); tick();

    // Reset state
    chk("rst_x", ifa.x, 0);
    chk("rst_y", ifa.y, 0);
    chk("rst_de", ifa.de, 1);
    chk("rst_line_start", ifa.line_start, 1);
    chk("rst_frame_start", ifa.frame_start, 1);
    chk("rst_frame_cnt", ifa.frame_cnt, 0);
    chk("rst_hsync_a", ifa.hsync, 1);
    chk("rst_vsync_a", ifa.vsync, 1);
    chk("rst_video_a", ifa.video, 0);
    chk("rst_hsync_b", ifb.hsync, 0);
    chk("rst_vsync_b", ifb.vsync, 1);

    // Defaults, ce=1, two lines
    reset_a = 1'b0;
    lowcnt = 0; first_low = -1;
    for (int n = 0; n < 1700; n++) begin
      chk("a_x", ifa.x, n % 800);
      chk("a_y", ifa.y, n / 800);
      chk("a_line_start", ifa.line_start, (n % 800) == 0);
      chk("a_frame_start", ifa.frame_start, n == 0);
      chk("a_de", ifa.de, (n % 800) < 640);
      if (n >= 2) begin
        hd = (n - 2) % 800; vd = (n - 2) / 800;
        chk("a_hsync", ifa.hsync, (hd >= 656 && hd < 752) ? 0 : 1);
        chk("a_video", ifa.video, (hd < 640 && vd < 480) ? 1 : 0);
      end else begin
        chk("a_hsync_fill", ifa.hsync, 1);
        chk("a_video_fill", ifa.video, 0);
      end
      if (n >= 800 && n < 1600 && ifa.hsync == 1'b0) begin
        lowcnt++;
        if (first_low < 0) first_low = n;
      end
      tick();
    end
    chk("a_hsync_width", lowcnt, 96);
    chk("a_hsync_start", first_low, 800 + 658);

    // ce toggling every other clk
    reset_a = 1'b1; tick(); reset_a = 1'b0;
    e = 0; ls_prev = 1; rise0 = -1; rise1 = -1; lowcnt = 0;
    for (int m = 0; m < 3300; m++) begin
      ifa.ce = (m % 2) == 0;
      chk("ce_x", ifa.x, e % 800);
      if (ifa.line_start && !ls_prev) begin
        if (rise0 < 0) rise0 = m; else if (rise1 < 0) rise1 = m;
      end
      ls_prev = ifa.line_start;
      if (m < 1600 && ifa.hsync == 1'b0) lowcnt++;
      tick();
      if ((m % 2) == 0) e++;
    end
    chk("ce_line_period", rise1 - rise0, 1600);
    chk("ce_hsync_width", lowcnt, 192);
    ifa.ce = 1'b1;

`ifdef VGA_TEST_PATTERN_EN
    // Checkerboard source
    reset_a = 1'b1; tick(); reset_a = 1'b0;
    ifa.test_mode = 1'b1; ifa.pix_in = 1'b0;
    for (int n = 0; n < 8 * 800 + 20; n++) begin
      if (n == 2)           chk("tp_x0_y0", ifa.video, 0);
      if (n == 10)          chk("tp_x8_y0", ifa.video, 1);
      if (n == 650)         chk("tp_blank", ifa.video, 0);
      if (n == 8 * 800 + 10) chk("tp_x8_y8", ifa.video, 0);
      tick();
    end
    ifa.test_mode = 1'b0; ifa.pix_in = 1'b1;
`endif

    // Small timing: 16 x 7, 256+ frames
    reset_b = 1'b0;
    for (int n = 0; n < 256 * 112 + 21; n++) begin
      if (n < 2 * 112) begin
        chk("b_x", ifb.x, n % 16);
        chk("b_y", ifb.y, (n / 16) % 7);
        chk("b_frame_start", ifb.frame_start, (n % 112) == 0);
        if (n >= 2) begin
          hd = (n - 2) % 16; vd = ((n - 2) / 16) % 7;
          chk("b_hsync", ifb.hsync, (hd >= 10 && hd <= 12) ? 1 : 0);
          chk("b_vsync", ifb.vsync, (vd == 5) ? 0 : 1);
          chk("b_video", ifb.video, (hd < 8 && vd < 4) ? 1 : 0);
        end
      end
      if ((n % 16) == 0) chk("b_frame_cnt", ifb.frame_cnt, (n / 112) % 256);
      if (n == 255 * 112) chk("b_frame_cnt_255", ifb.frame_cnt, 255);
      if (n == 256 * 112) chk("b_frame_cnt_wrap", ifb.frame_cnt, 0);
      tick();
    end

    // Reset mid-frame with ce low
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (ifb.x == 10'd5 && ifb.y == 10'd2) found = 1'b1;
      else tick();
    end
    chk("b_reach_5_2", found, 1);
    chk("b_pre_rst_video", ifb.video, 1);
    ifb.ce = 1'b0; reset_b = 1'b1;
    tick();
    chk("mid_rst_x", ifb.x, 0);
    chk("mid_rst_y", ifb.y, 0);
    chk("mid_rst_hsync", ifb.hsync, 0);
    chk("mid_rst_vsync", ifb.vsync, 1);
    chk("mid_rst_video", ifb.video, 0);
    chk("mid_rst_frame_start", ifb.frame_start, 1);
    ifb.ce = 1'b1; reset_b = 1'b0;
    tick();
    chk("post_rst_x", ifb.x, 1);
    chk("post_rst_y", ifb.y, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
